// File: rtl/rv32i_alu.sv
// rv32i_alu: registered 32-bit integer ALU for the RV32I execute stage.
// Evaluates the ten RV32I register-register operations selected by alu_ctrl
// and registers the result, a zero flag and a valid pulse (1-cycle latency).
// Optional feature macro: ALU_PASS_B_EN -- when defined, alu_ctrl 4'b1010
// passes operand b through to the result (LUI / immediate pass-through);
// when undefined, 4'b1010 behaves like the other unused codes (result 0).
`timescale 1ns/1ps

module rv32i_alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_ctrl,
   input  logic        in_valid,
   output logic [31:0] result,
   output logic        zero,
   output logic        out_valid
);

   typedef enum logic [3:0] {
      ALU_ADD    = 4'b0000,
      ALU_SUB    = 4'b0001,
      ALU_AND    = 4'b0010,
      ALU_OR     = 4'b0011,
      ALU_XOR    = 4'b0100,
      ALU_SLL    = 4'b0101,
      ALU_SRL    = 4'b0110,
      ALU_SRA    = 4'b0111,
      ALU_SLT    = 4'b1000,
      ALU_SLTU   = 4'b1001,
      ALU_PASS_B = 4'b1010
   } alu_op_e;

   alu_op_e     op;
   logic [4:0]  shamt;
   logic [31:0] alu_res;

   logic [31:0] result_d, result_q;
   logic        zero_d, zero_q;
   logic        out_valid_d, out_valid_q;

   // Codes 1011..1111 are not enum members; they fall to the default arm.
   assign op    = alu_op_e'(alu_ctrl);
   // Only the low five bits of b shift, so a shift by 32 acts as a shift by 0.
   assign shamt = b[4:0];

   // Combinational operation datapath; unused codes produce zero.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred for codes the case does not list.
      alu_res = '0;
      case (op)
         ALU_ADD:    alu_res = a + b;
         ALU_SUB:    alu_res = a - b;
         ALU_AND:    alu_res = a & b;
         ALU_OR:     alu_res = a | b;
         ALU_XOR:    alu_res = a ^ b;
         ALU_SLL:    alu_res = a << shamt;
         ALU_SRL:    alu_res = a >> shamt;
         ALU_SRA:    alu_res = $signed(a) >>> shamt;
         ALU_SLT:    alu_res = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU:   alu_res = {31'b0, a < b};
`ifdef ALU_PASS_B_EN
         ALU_PASS_B: alu_res = b;
`else
         ALU_PASS_B: alu_res = '0;
`endif
         default:    alu_res = '0;
      endcase
   end

   // Next-state: capture on in_valid, otherwise hold result/zero and drop valid.
   always_comb begin
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         result_d = alu_res;
         // zero comes from the very value being loaded, not from result_q.
         zero_d   = (alu_res == 32'd0);
      end
   end

   // Output registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before this edge, independent of statement order.
      if (!rst_n) begin
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: expected results are pushed to a
// scoreboard queue when an operation is driven and popped one edge later.
`timescale 1ns/1ps

module tb_rv32i_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b;
   logic [3:0]  alu_ctrl;
   logic        in_valid;
   logic [31:0] result;
   logic        zero;
   logic        out_valid;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rv32i_alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .alu_ctrl  (alu_ctrl),
      .in_valid  (in_valid),
      .result    (result),
      .zero      (zero),
      .out_valid (out_valid)
   );

   // Reference model, written independently of the RTL operators.
   function automatic logic [31:0] alu_model(input logic [3:0] c,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
      logic [4:0]  sh;
      logic [31:0] fill;
      sh = y[4:0];
      fill = x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
      case (c)
         4'd0:    return x + y;
         4'd1:    return x + ~y + 32'd1;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return x ^ y;
         4'd5:    return x << sh;
         4'd6:    return x >> sh;
         4'd7:    return (x >> sh) | fill;
         4'd8:    return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
         4'd9:    return {31'd0, x < y};
`ifdef ALU_PASS_B_EN
         4'd10:   return y;
`endif
         default: return 32'd0;
      endcase
   endfunction

   // Drive one valid operation and record what it must produce.
   task automatic send(input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_res);
      exp_t e;
      alu_ctrl = c;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      e.res    = exp_res;
      e.zero   = (exp_res == 32'd0);
      sb.push_back(e);
   endtask

   task automatic go_idle();
      in_valid = 1'b0;
      alu_ctrl = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      alu_ctrl = 4'b0000;
      a        = 32'd5;
      b        = 32'd3;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset[%0d]: got r=%h z=%b v=%b, want r=0 z=1 v=0",
                     i, result, zero, out_valid);
         end
      end
      rst_n = 1'b1;
      go_idle();
      @(posedge clk); #1;
      checks++;
      if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got r=%h z=%b v=%b, want r=0 z=1 v=0",
                  result, zero, out_valid);
      end
   endtask

   task automatic test_arith();
      logic [3:0]  c[3]  = '{4'b0000, 4'b0001, 4'b0000};
      logic [31:0] x[3]  = '{32'd5, 32'd5, 32'hFFFF_FFFF};
      logic [31:0] y[3]  = '{32'd3, 32'd7, 32'd1};
      logic [31:0] r[3]  = '{32'd8, 32'hFFFF_FFFE, 32'd0};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         send(c[i], x[i], y[i], r[i]);
         @(posedge clk); #1;
         go_idle();
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL arith[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero) begin
               errors++;
               $display("FAIL arith[%0d]: got v=%b r=%h z=%b, want v=1 r=%h z=%b",
                        i, out_valid, result, zero, e.res, e.zero);
            end
         end
         // The pulse must last exactly one edge.
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || result !== r[i]) begin
            errors++;
            $display("FAIL arith_pulse[%0d]: got v=%b r=%h, want v=0 r=%h",
                     i, out_valid, result, r[i]);
         end
      end
   endtask

   task automatic test_logic();
      logic [3:0]  c[3] = '{4'b0010, 4'b0011, 4'b0100};
      logic [31:0] r[3] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         send(c[i], 32'hF0F0_F0F0, 32'h0F0F_0F0F, r[i]);
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL logic[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero) begin
               errors++;
               $display("FAIL logic[%0d]: got v=%b r=%h z=%b, want v=1 r=%h z=%b",
                        i, out_valid, result, zero, e.res, e.zero);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_shift();
      logic [3:0]  c[4] = '{4'b0101, 4'b0110, 4'b0111, 4'b0101};
      logic [31:0] x[4] = '{32'd1, 32'h10, 32'hFFFF_FFF8, 32'd1};
      logic [31:0] y[4] = '{32'd4, 32'd1, 32'd1, 32'h0000_0021};
      logic [31:0] r[4] = '{32'h10, 32'h8, 32'hFFFF_FFFC, 32'h2};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         send(c[i], x[i], y[i], r[i]);
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL shift[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero) begin
               errors++;
               $display("FAIL shift[%0d]: got v=%b r=%h z=%b, want v=1 r=%h z=%b",
                        i, out_valid, result, zero, e.res, e.zero);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_compare();
      logic [3:0]  c[4] = '{4'b1000, 4'b1001, 4'b1111, 4'b1010};
      logic [31:0] x[4] = '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
      logic [31:0] y[4] = '{32'd3, 32'd3, 32'd3, 32'h1234_5000};
`ifdef ALU_PASS_B_EN
      logic [31:0] r[4] = '{32'd1, 32'd0, 32'd0, 32'h1234_5000};
`else
      logic [31:0] r[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
`endif
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         send(c[i], x[i], y[i], r[i]);
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL compare[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero) begin
               errors++;
               $display("FAIL compare[%0d]: got v=%b r=%h z=%b, want v=1 r=%h z=%b",
                        i, out_valid, result, zero, e.res, e.zero);
            end
         end
      end
      go_idle();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  c;
      logic [31:0] x, y;
      exp_t        e, last;
      last = '0;
      // First op is issued here; each later op is issued in the same step
      // as the previous one is checked, so in_valid never drops.
      for (int i = 0; i < 10; i++) begin
         c = (i < 8) ? 4'(i) : 4'($urandom_range(8, 15));
         x = $urandom;
         y = (i == 2) ? 32'd0 : $urandom;
         send(c, x, y, alu_model(c, x, y));
         @(posedge clk); #1;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL stream[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            last = e;
            if (out_valid !== 1'b1 || result !== e.res || zero !== e.zero) begin
               errors++;
               $display("FAIL stream[%0d]: got v=%b r=%h z=%b, want v=1 r=%h z=%b",
                        i, out_valid, result, zero, e.res, e.zero);
            end
         end
      end
      go_idle();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         go_idle();
         checks++;
         if (out_valid !== 1'b0 || result !== last.res || zero !== last.zero) begin
            errors++;
            $display("FAIL stream_gap[%0d]: got v=%b r=%h z=%b, want v=0 r=%h z=%b",
                     i, out_valid, result, zero, last.res, last.zero);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_compare();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
